spi_boot_loader: RTL and testbench

- Post-reset boot sequencer that acts as APB master to spi_controller and copies an image from an external SPI flash into data_ram.
- Holds the CPU stalled through the copy and asserts boot_done when it finishes.
- Sits upstream of spi_controller and data_ram. Its APB and RAM outputs are muxed with memory_map_decoder's outputs under cpu_hold at SoC top.
- Flash protocol: standard READ (0x03), 24-bit address, then data bytes clocked by dummy writes.

---
 rtl/spi_boot_loader.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_boot_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_boot_loader.sv
// spi_boot_loader
//   Post-reset boot sequencer. Acts as APB master to spi_controller, reads
//   BOOT_LEN bytes from an external SPI flash with the standard READ (0x03)
//   command and copies them, packed little-endian into 32-bit words, into
//   data_ram. The CPU is held (cpu_hold) for the whole copy.
//
// Ports
//   clk, reset                     system clock, synchronous active-high reset
//   spi_psel/penable/pwrite/paddr/pwdata
//                                  APB master request to spi_controller
//   spi_prdata, spi_pready         APB read data / ready from spi_controller
//   ram_cs, ram_we, ram_addr, ram_wdata
//                                  single-cycle word write into data_ram
//   cpu_hold                       stalls CPU, selects loader paths at SoC top
//   boot_done                      image copied successfully (sticky)
//   boot_error                     STATUS poll timeout (sticky)
module spi_boot_loader #(
  parameter logic [23:0] FLASH_ADDR = 24'h000000,
  parameter logic [15:0] BOOT_LEN   = 16'd256,
  parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
  parameter logic [15:0] TIMEOUT    = 16'd1023,
  parameter logic [2:0]  REG_CTRL   = 3'h0,
  parameter logic [2:0]  REG_STATUS = 3'h1,
  parameter logic [2:0]  REG_TX     = 3'h2,
  parameter logic [2:0]  REG_RX     = 3'h3
) (
  input  logic        clk,
  input  logic        reset,
  output logic        spi_psel,
  output logic        spi_penable,
  output logic        spi_pwrite,
  output logic [2:0]  spi_paddr,
  output logic [7:0]  spi_pwdata,
  input  logic [7:0]  spi_prdata,
  input  logic        spi_pready,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        cpu_hold,
  output logic        boot_done,
  output logic        boot_error
);

  typedef enum logic [2:0] {
    S_CFG, S_CMD, S_DATA, S_WR, S_REL, S_DONE, S_ERR, S_HALT
  } state_t;

  typedef enum logic [1:0] {B_TX, B_POLL, B_RX} byte_t;

  typedef enum logic [1:0] {P_IDLE, P_SETUP, P_ACCESS} phase_t;

  state_t      state;
  byte_t       bstate;
  phase_t      phase;
  logic [15:0] cnt;   // command byte index in CMD, data byte index in DATA/WR
  logic [15:0] tmo;
  logic [31:0] acc;

  logic        req_write;
  logic [2:0]  req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  cmd_byte;
  logic [31:0] acc_merged;
  logic        last_byte;
  logic        poll_expired;
  logic [31:0] word_addr;

  always_comb begin
    cmd_byte = 8'h03;
    case (cnt[1:0])
      2'd0: cmd_byte = 8'h03;
      2'd1: cmd_byte = FLASH_ADDR[23:16];
      2'd2: cmd_byte = FLASH_ADDR[15:8];
      2'd3: cmd_byte = FLASH_ADDR[7:0];
      default: cmd_byte = 8'h03;
    endcase
  end

  // Transaction to launch from the current state when the bus is idle.
  always_comb begin
    req_write = 1'b0;
    req_addr  = REG_CTRL;
    req_wdata = '0;
    case (state)
      S_CFG: begin
        req_write = 1'b1;
        req_addr  = REG_CTRL;
        req_wdata = 8'h01;
      end
      S_CMD, S_DATA: begin
        case (bstate)
          B_TX: begin
            req_write = 1'b1;
            req_addr  = REG_TX;
            req_wdata = (state == S_CMD) ? cmd_byte : 8'h00;
          end
          B_POLL:  req_addr = REG_STATUS;
          B_RX:    req_addr = REG_RX;
          default: req_addr = REG_STATUS;
        endcase
      end
      S_REL, S_ERR: begin
        req_write = 1'b1;
        req_addr  = REG_CTRL;
        req_wdata = 8'h00;
      end
      default: ;
    endcase
  end

  assign acc_merged   = acc | (32'(spi_prdata) << {cnt[1:0], 3'b000});
  assign last_byte    = (cnt == BOOT_LEN - 16'd1);
  assign poll_expired = ({1'b0, tmo} + 17'd1) >= {1'b0, TIMEOUT};
  assign word_addr    = RAM_BASE + {16'b0, cnt[15:2], 2'b00};

  // Each APB transaction is IDLE -> SETUP -> ACCESS(+waits); the IDLE cycle
  // guarantees psel/penable are low for a cycle between transactions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_CFG;
      bstate      <= B_TX;
      phase       <= P_IDLE;
      cnt         <= '0;
      tmo         <= '0;
      acc         <= '0;
      spi_psel    <= 1'b0;
      spi_penable <= 1'b0;
      spi_pwrite  <= 1'b0;
      spi_paddr   <= '0;
      spi_pwdata  <= '0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      cpu_hold    <= 1'b1;
      boot_done   <= 1'b0;
      boot_error  <= 1'b0;
    end else begin
      case (state)
        S_WR: begin
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          if (last_byte) begin
            state <= S_REL;
          end else begin
            cnt    <= cnt + 16'd1;
            state  <= S_DATA;
            bstate <= B_TX;
          end
        end
        S_DONE, S_HALT: ;
        default: begin
          case (phase)
            P_IDLE: begin
              spi_psel    <= 1'b1;
              spi_penable <= 1'b0;
              spi_pwrite  <= req_write;
              spi_paddr   <= req_addr;
              spi_pwdata  <= req_wdata;
              phase       <= P_SETUP;
            end
            P_SETUP: begin
              spi_penable <= 1'b1;
              phase       <= P_ACCESS;
            end
            P_ACCESS: begin
              if (spi_pready) begin
                spi_psel    <= 1'b0;
                spi_penable <= 1'b0;
                phase       <= P_IDLE;
                case (state)
                  S_CFG: begin
                    state  <= S_CMD;
                    bstate <= B_TX;
                    cnt    <= '0;
                  end
                  S_CMD, S_DATA: begin
                    case (bstate)
                      B_TX: begin
                        bstate <= B_POLL;
                        tmo    <= '0;
                      end
                      B_POLL: begin
                        if (spi_prdata[0]) begin
                          bstate <= B_RX;
                        end else begin
                          tmo <= tmo + 16'd1;
                          if (poll_expired) state <= S_ERR;
                        end
                      end
                      B_RX: begin
                        bstate <= B_TX;
                        if (state == S_CMD) begin
                          if (cnt[1:0] == 2'd3) begin
                            state <= S_DATA;
                            cnt   <= '0;
                          end else begin
                            cnt <= cnt + 16'd1;
                          end
                        end else if (cnt[1:0] == 2'd3 || last_byte) begin
                          state     <= S_WR;
                          ram_cs    <= 1'b1;
                          ram_we    <= 1'b1;
                          ram_addr  <= word_addr;
                          ram_wdata <= acc_merged;
                          acc       <= '0;
                        end else begin
                          acc <= acc_merged;
                          cnt <= cnt + 16'd1;
                        end
                      end
                      default: bstate <= B_TX;
                    endcase
                  end
                  S_REL: begin
                    state     <= S_DONE;
                    cpu_hold  <= 1'b0;
                    boot_done <= 1'b1;
                  end
                  S_ERR: begin
                    state      <= S_HALT;
                    boot_error <= 1'b1;
                  end
                  default: ;
                endcase
              end
            end
            default: phase <= P_IDLE;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_boot_loader.sv
// tb_spi_boot_loader
//   Three loader instances share one behavioural spi_controller/flash model;
//   the instance not under test is held in reset. Directed scenarios with
//   hand-computed expectations.
module tb_spi_boot_loader;

  localparam logic [2:0] A_CTRL = 3'h0;
  localparam logic [2:0] A_STAT = 3'h1;
  localparam logic [2:0] A_TX   = 3'h2;
  localparam logic [2:0] A_RX   = 3'h3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v = 3'b111;
  logic [1:0]  sel = 2'd0;
  logic [2:0]  psel_v, penable_v, pwrite_v, ram_cs_v, ram_we_v, hold_v, done_v, err_v;
  logic [2:0]  paddr_v [3];
  logic [7:0]  pwdata_v [3];
  logic [31:0] ram_addr_v [3];
  logic [31:0] ram_wdata_v [3];
  logic [7:0]  prdata;
  logic        pready_r = 1'b1;

  spi_boot_loader #(.BOOT_LEN(16'd8)) u_a (
    .clk(clk), .reset(rst_v[0]),
    .spi_psel(psel_v[0]), .spi_penable(penable_v[0]), .spi_pwrite(pwrite_v[0]),
    .spi_paddr(paddr_v[0]), .spi_pwdata(pwdata_v[0]),
    .spi_prdata(prdata), .spi_pready(pready_r),
    .ram_cs(ram_cs_v[0]), .ram_we(ram_we_v[0]), .ram_addr(ram_addr_v[0]),
    .ram_wdata(ram_wdata_v[0]), .cpu_hold(hold_v[0]), .boot_done(done_v[0]),
    .boot_error(err_v[0])
  );

  spi_boot_loader #(.BOOT_LEN(16'd5), .RAM_BASE(32'h0000_0100), .FLASH_ADDR(24'h012345)) u_b (
    .clk(clk), .reset(rst_v[1]),
    .spi_psel(psel_v[1]), .spi_penable(penable_v[1]), .spi_pwrite(pwrite_v[1]),
    .spi_paddr(paddr_v[1]), .spi_pwdata(pwdata_v[1]),
    .spi_prdata(prdata), .spi_pready(pready_r),
    .ram_cs(ram_cs_v[1]), .ram_we(ram_we_v[1]), .ram_addr(ram_addr_v[1]),
    .ram_wdata(ram_wdata_v[1]), .cpu_hold(hold_v[1]), .boot_done(done_v[1]),
    .boot_error(err_v[1])
  );

  spi_boot_loader #(.BOOT_LEN(16'd8), .TIMEOUT(16'd4)) u_c (
    .clk(clk), .reset(rst_v[2]),
    .spi_psel(psel_v[2]), .spi_penable(penable_v[2]), .spi_pwrite(pwrite_v[2]),
    .spi_paddr(paddr_v[2]), .spi_pwdata(pwdata_v[2]),
    .spi_prdata(prdata), .spi_pready(pready_r),
    .ram_cs(ram_cs_v[2]), .ram_we(ram_we_v[2]), .ram_addr(ram_addr_v[2]),
    .ram_wdata(ram_wdata_v[2]), .cpu_hold(hold_v[2]), .boot_done(done_v[2]),
    .boot_error(err_v[2])
  );

  logic        m_psel, m_penable, m_pwrite, m_ram_cs, m_ram_we, m_hold, m_done, m_err;
  logic [2:0]  m_paddr;
  logic [7:0]  m_pwdata;
  logic [31:0] m_ram_addr, m_ram_wdata;
  assign m_psel      = psel_v[sel];
  assign m_penable   = penable_v[sel];
  assign m_pwrite    = pwrite_v[sel];
  assign m_paddr     = paddr_v[sel];
  assign m_pwdata    = pwdata_v[sel];
  assign m_ram_cs    = ram_cs_v[sel];
  assign m_ram_we    = ram_we_v[sel];
  assign m_ram_addr  = ram_addr_v[sel];
  assign m_ram_wdata = ram_wdata_v[sel];
  assign m_hold      = hold_v[sel];
  assign m_done      = done_v[sel];
  assign m_err       = err_v[sel];

  // Flash / spi_controller model state
  logic [7:0]  img [16];
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  bit          never_ready = 1'b0;
  int          nwait = 0, wcnt = 0, tx_cnt = 0;
  int          status_reads = 0, rx_reads = 0, wait_cycles = 0, stab_err = 0, gap_err = 0;
  logic [10:0] wr_q [$];
  logic [63:0] ram_q [$];
  logic        prev_psel = 0, prev_pen = 0, prev_pwrite = 0, prev_ready = 0;
  logic [2:0]  prev_addr = 0;
  logic [7:0]  prev_wdata = 0;

  assign prdata = (m_paddr == A_STAT) ? {7'b0, rx_valid} :
                  (m_paddr == A_RX)   ? rx_byte : 8'h00;

  always @(negedge clk) begin
    if (rst_v[sel]) begin
      tx_cnt = 0; rx_valid = 1'b0; rx_byte = 8'h00; wcnt = 0; pready_r = 1'b1;
      prev_psel = 0; prev_pen = 0; prev_ready = 0;
    end else begin
      if (!(m_psel && m_penable)) wcnt = 0;
      pready_r = (wcnt >= nwait);
      // request must be held unchanged from setup through every wait cycle
      if (prev_psel && (!prev_pen || !prev_ready)) begin
        if (!(m_psel && m_penable && m_paddr == prev_addr && m_pwdata == prev_wdata &&
              m_pwrite == prev_pwrite))
          stab_err++;
      end
      if (prev_psel && prev_pen && prev_ready && m_psel) gap_err++;
      prev_psel = m_psel; prev_pen = m_penable; prev_pwrite = m_pwrite;
      prev_addr = m_paddr; prev_wdata = m_pwdata; prev_ready = pready_r;
      if (m_psel && m_penable && !pready_r) begin
        wait_cycles++;
        wcnt++;
      end else if (m_psel && m_penable) begin
        wcnt = 0;
        if (m_pwrite) begin
          wr_q.push_back({m_paddr, m_pwdata});
          if (m_paddr == A_TX) begin
            rx_byte = (tx_cnt < 4) ? 8'hFF : img[tx_cnt - 4];
            tx_cnt++;
            if (!never_ready) rx_valid = 1'b1;
          end
        end else begin
          if (m_paddr == A_STAT) status_reads++;
          if (m_paddr == A_RX) begin
            rx_valid = 1'b0;
            rx_reads++;
          end
        end
      end
      if (m_ram_cs && m_ram_we) ram_q.push_back({m_ram_addr, m_ram_wdata});
    end
  end

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [2:0] a, input logic [7:0] d);
    logic [10:0] got;
    got = (idx < wr_q.size()) ? wr_q[idx] : 11'h7ff;
    chk($sformatf("%s_apbwr%0d", tag, idx), 64'(got), 64'({a, d}));
  endtask

  task automatic chk_ram(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] got;
    got = (idx < ram_q.size()) ? ram_q[idx] : '1;
    chk($sformatf("%s_ram%0d", tag, idx), got, {a, d});
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctrl_outs"},
        64'({m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_ram_cs, m_ram_we, m_hold, m_done, m_err}),
        64'h4);
    chk({tag, "_ram_bus"}, {m_ram_addr, m_ram_wdata}, 64'h0);
  endtask

  task automatic clear_logs();
    wr_q.delete(); ram_q.delete();
    status_reads = 0; rx_reads = 0; wait_cycles = 0; stab_err = 0; gap_err = 0;
  endtask

  task automatic start_boot(input logic [1:0] s, input int w, input bit nr, input string tag);
    @(negedge clk);
    rst_v = 3'b111; sel = s; nwait = w; never_ready = nr;
    repeat (3) @(negedge clk);
    chk_reset_outs(tag);
    clear_logs();
    rst_v[s] = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string tag);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (m_done || m_err) ok = 1;
    end
    chk({tag, "_end_in_budget"}, 64'(ok), 64'd1);
  endtask

  // BOOT_LEN=8 image 10..17 from flash address 0 to RAM 0
  task automatic chk_seq(input string tag);
    chk({tag, "_apbwr_count"}, 64'(wr_q.size()), 64'd14);
    for (int k = 0; k < 14; k++) begin
      if (k == 0)       chk_wr(tag, k, A_CTRL, 8'h01);
      else if (k == 1)  chk_wr(tag, k, A_TX, 8'h03);
      else if (k == 13) chk_wr(tag, k, A_CTRL, 8'h00);
      else              chk_wr(tag, k, A_TX, 8'h00);
    end
    chk({tag, "_status_reads"}, 64'(status_reads), 64'd12);
    chk({tag, "_ram_count"}, 64'(ram_q.size()), 64'd2);
    chk_ram(tag, 0, 32'h0, 32'h13121110);
    chk_ram(tag, 1, 32'h4, 32'h17161514);
    chk({tag, "_hold_done_err"}, 64'({m_hold, m_done, m_err}), 64'b010);
    chk({tag, "_gap"}, 64'(gap_err), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) img[i] = 8'h10 + 8'(i);

    // plain sequence
    start_boot(2'd0, 0, 1'b0, "seq");
    wait_end(3000, "seq");
    chk_seq("seq");

    // three wait states on every access
    start_boot(2'd0, 3, 1'b0, "wait");
    wait_end(6000, "wait");
    chk_seq("wait");
    chk("wait_stable", 64'(stab_err), 64'd0);
    chk("wait_cycles", 64'(wait_cycles), 64'd114);

    // reset after the second data byte, then a clean restart
    begin
      bit reached = 0;
      start_boot(2'd0, 0, 1'b0, "mid");
      for (int i = 0; i < 500 && !reached; i++) begin
        @(negedge clk);
        if (rx_reads >= 6) reached = 1;
      end
      chk("mid_reached_byte2", 64'(reached), 64'd1);
      repeat (2) @(negedge clk);
      rst_v[0] = 1'b1;
      @(negedge clk);
      chk_reset_outs("mid_rst");
      chk("mid_no_ram_write", 64'(ram_q.size()), 64'd0);
      clear_logs();
      @(negedge clk);
      rst_v[0] = 1'b0;
      wait_end(3000, "mid");
      chk_seq("mid");
    end

    // partial last word, non-zero flash and RAM bases
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD; img[4] = 8'hEE;
    start_boot(2'd1, 0, 1'b0, "part");
    wait_end(3000, "part");
    chk("part_apbwr_count", 64'(wr_q.size()), 64'd11);
    chk_wr("part", 0, A_CTRL, 8'h01);
    chk_wr("part", 1, A_TX, 8'h03);
    chk_wr("part", 2, A_TX, 8'h01);
    chk_wr("part", 3, A_TX, 8'h23);
    chk_wr("part", 4, A_TX, 8'h45);
    chk_wr("part", 10, A_CTRL, 8'h00);
    chk("part_ram_count", 64'(ram_q.size()), 64'd2);
    chk_ram("part", 0, 32'h100, 32'hDDCCBBAA);
    chk_ram("part", 1, 32'h104, 32'h000000EE);
    chk("part_hold_done_err", 64'({m_hold, m_done, m_err}), 64'b010);

    // rx_valid never rises, TIMEOUT=4
    start_boot(2'd2, 0, 1'b1, "tmo");
    wait_end(2000, "tmo");
    repeat (20) @(negedge clk);
    chk("tmo_status_reads", 64'(status_reads), 64'd4);
    chk("tmo_apbwr_count", 64'(wr_q.size()), 64'd3);
    chk_wr("tmo", 0, A_CTRL, 8'h01);
    chk_wr("tmo", 1, A_TX, 8'h03);
    chk_wr("tmo", 2, A_CTRL, 8'h00);
    chk("tmo_ram_count", 64'(ram_q.size()), 64'd0);
    chk("tmo_hold_done_err", 64'({m_hold, m_done, m_err}), 64'b101);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
